// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;
    localparam int unsigned FETCH_PC_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_buffer.sv
// One-entry valid/ready holding register between fetch and decode.
// A clear wins over a load so a redirect can never leave a stale word behind.
module fetch_stage_buffer
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         out_ready,
    output logic         out_valid,
    output fetch_entry_t entry
);

    // Hold the entry until the decoder takes it; reload or clear as commanded.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_valid <= 1'b0;
            entry     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            entry     <= load_entry;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs one i-bus request at a time and
// hands fetched words to the decoder through a one-entry buffer. Redirects
// replace the PC and kill any in-flight or buffered fetch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  req_addr, req_addr_next;
    logic         kill_pending, kill_next;
    logic         adel_done, adel_next;
    logic         buf_load;
    logic         buf_valid;
    logic         can_issue;
    fetch_entry_t buf_in;
    fetch_entry_t buf_out;

    // The buffer is free when empty or being drained by the decoder this cycle.
    assign can_issue = !buf_valid || out_ready;

    // The request address is latched at issue so a redirect during REQ cannot disturb it.
    assign ireq_valid = (state == REQ);
    assign ireq_addr  = req_addr;

    assign out_valid = buf_valid;
    assign out_instr = buf_out.instr;
    assign out_pc    = buf_out.pc;
    assign out_adel  = buf_out.adel;

    // State, PC and kill bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            kill_pending <= 1'b0;
            adel_done    <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            req_addr     <= req_addr_next;
            kill_pending <= kill_next;
            adel_done    <= adel_next;
        end
    end

    // Next-state, PC update and buffer fill; a redirect always takes the PC.
    // A misaligned PC yields a single AdEL entry until the next redirect.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        kill_next     = kill_pending;
        adel_next     = adel_done;
        buf_load      = 1'b0;
        buf_in        = '0;

        if (redirect_valid) begin
            pc_next   = redirect_pc;
            adel_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!redirect_valid && can_issue) begin
                    if (pc[1:0] == 2'b00) begin
                        state_next    = REQ;
                        req_addr_next = pc;
                    end else if (!adel_done) begin
                        buf_load    = 1'b1;
                        buf_in.pc   = pc;
                        buf_in.adel = 1'b1;
                        adel_next   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    kill_next = 1'b1;
                end
                if (ireq_ready) begin
                    state_next = (kill_pending || redirect_valid) ? DROP : WAIT;
                    kill_next  = 1'b0;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = iresp_valid ? IDLE : DROP;
                end else if (iresp_valid) begin
                    buf_load     = 1'b1;
                    buf_in.instr = iresp_data;
                    buf_in.pc    = pc;
                    pc_next      = pc + 32'(PC_STEP);
                    state_next   = IDLE;
                end
            end
            DROP: begin
                if (iresp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_stage_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .load       (buf_load),
        .load_entry (buf_in),
        .out_ready  (out_ready),
        .out_valid  (buf_valid),
        .entry      (buf_out)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed protocol scenarios followed by
// a randomized run checked against a stream-level model of the decoder's view.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_adel;

    int n_assert = 0;
    int n_fail   = 0;

    // Random-phase bus responder and stream model state.
    logic        pending;
    int          resp_delay;
    logic [31:0] resp_addr;
    logic [31:0] exp_pc;
    logic        expect_none;
    int          deliveries;
    logic        req_fire;
    logic [31:0] fire_addr;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_adel       (out_adel)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image seen by the random phase: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_1E0F;
    endfunction

    // Let one rising edge consume the staged inputs, then settle at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ireq_valid"}, 32'(ireq_valid), 32'd0);
        checkOutput({tag, " out_valid"},  32'(out_valid),  32'd0);
        checkOutput({tag, " out_adel"},   32'(out_adel),   32'd0);
        checkOutput({tag, " out_instr"},  out_instr,       32'd0);
        checkOutput({tag, " out_pc"},     out_pc,          32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        ireq_ready     = 1'b0;
        iresp_valid    = 1'b0;
        iresp_data     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        @(negedge clk);
        applyStimulus();
        checkResetOutputs("reset");

        // 1: first fetch after reset with an always-ready bus.
        reset      = 1'b0;
        ireq_ready = 1'b1;
        applyStimulus();
        checkOutput("t1 req valid", 32'(ireq_valid), 32'd1);
        checkOutput("t1 req addr", ireq_addr, RESET_PC);
        applyStimulus();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'h2408_0001;
        checkOutput("t1 req dropped after accept", 32'(ireq_valid), 32'd0);
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1 out_pc", out_pc, RESET_PC);
        checkOutput("t1 out_instr", out_instr, 32'h2408_0001);
        checkOutput("t1 out_adel", 32'(out_adel), 32'd0);

        // 2: decoder back-pressure holds the buffer and blocks new requests.
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("t2 hold out_valid", 32'(out_valid), 32'd1);
            checkOutput("t2 hold out_instr", out_instr, 32'h2408_0001);
            checkOutput("t2 hold out_pc", out_pc, RESET_PC);
            checkOutput("t2 no request", 32'(ireq_valid), 32'd0);
        end
        out_ready  = 1'b1;
        ireq_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("t2 drained", 32'(out_valid), 32'd0);
        checkOutput("t2 resume req", 32'(ireq_valid), 32'd1);
        checkOutput("t2 next addr", ireq_addr, RESET_PC + 32'd4);
        applyStimulus();
        ireq_ready = 1'b0;

        // 3: redirect while waiting for the response.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        applyStimulus();
        redirect_valid = 1'b0;
        iresp_valid    = 1'b1;
        iresp_data     = 32'hDEAD_BEEF;
        checkOutput("t3 no req in drop", 32'(ireq_valid), 32'd0);
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t3 stale dropped", 32'(out_valid), 32'd0);
        applyStimulus();
        checkOutput("t3 req valid", 32'(ireq_valid), 32'd1);
        checkOutput("t3 req addr", ireq_addr, 32'h8000_0100);
        ireq_ready = 1'b1;
        applyStimulus();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'h1111_2222;
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t3 out_valid", 32'(out_valid), 32'd1);
        checkOutput("t3 out_pc", out_pc, 32'h8000_0100);
        checkOutput("t3 out_instr", out_instr, 32'h1111_2222);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("t3 drain", 32'(out_valid), 32'd0);
        checkOutput("t3 refetch valid", 32'(ireq_valid), 32'd1);
        checkOutput("t3 refetch addr", ireq_addr, 32'h8000_0104);

        // 4: redirect during a stalled request.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        applyStimulus();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("t4 stall valid", 32'(ireq_valid), 32'd1);
            checkOutput("t4 stall addr", ireq_addr, 32'h8000_0104);
            applyStimulus();
        end
        checkOutput("t4 stall addr last", ireq_addr, 32'h8000_0104);
        ireq_ready = 1'b1;
        applyStimulus();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'hDEAD_BEEF;
        checkOutput("t4 no req in drop", 32'(ireq_valid), 32'd0);
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t4 stale dropped", 32'(out_valid), 32'd0);
        applyStimulus();
        checkOutput("t4 target valid", 32'(ireq_valid), 32'd1);
        checkOutput("t4 target addr", ireq_addr, 32'h8000_0200);
        ireq_ready = 1'b1;
        applyStimulus();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'h3333_4444;
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t4 out_pc", out_pc, 32'h8000_0200);
        checkOutput("t4 out_instr", out_instr, 32'h3333_4444);

        // 5: misaligned redirect produces a single AdEL entry and no bus access.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("t5 buffer cleared", 32'(out_valid), 32'd0);
        checkOutput("t5 no req", 32'(ireq_valid), 32'd0);
        applyStimulus();
        checkOutput("t5 out_valid", 32'(out_valid), 32'd1);
        checkOutput("t5 out_adel", 32'(out_adel), 32'd1);
        checkOutput("t5 out_instr", out_instr, 32'd0);
        checkOutput("t5 out_pc", out_pc, 32'h8000_0102);
        checkOutput("t5 no req fill", 32'(ireq_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("t5 parked out_valid", 32'(out_valid), 32'd0);
            checkOutput("t5 parked no req", 32'(ireq_valid), 32'd0);
        end

        // 6: reset in WAIT; a late response must be ignored.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("t6 no req on redirect", 32'(ireq_valid), 32'd0);
        applyStimulus();
        checkOutput("t6 req addr", ireq_addr, 32'h8000_0300);
        ireq_ready = 1'b1;
        applyStimulus();
        ireq_ready = 1'b0;
        reset      = 1'b1;
        applyStimulus();
        reset       = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'h9999_9999;
        checkResetOutputs("t6 reset");
        applyStimulus();
        iresp_valid = 1'b0;
        checkOutput("t6 late resp ignored", 32'(out_valid), 32'd0);
        checkOutput("t6 restart valid", 32'(ireq_valid), 32'd1);
        checkOutput("t6 restart addr", ireq_addr, RESET_PC);

        // Randomized run: decoder sees pc, pc+4, ... after each redirect target.
        reset      = 1'b1;
        ireq_ready = 1'b0;
        out_ready  = 1'b0;
        applyStimulus();
        applyStimulus();
        reset       = 1'b0;
        pending     = 1'b0;
        resp_delay  = 0;
        resp_addr   = 32'd0;
        exp_pc      = RESET_PC;
        expect_none = 1'b0;
        deliveries  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = 32'h8000_1000 | (32'($urandom_range(0, 255)) << 2)
                                       | 32'($urandom_range(1, 3));
                default: redirect_pc = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
            endcase
            iresp_valid = pending && (resp_delay == 0);
            iresp_data  = iresp_valid ? mem_word(resp_addr) : $urandom;
            ireq_ready  = ireq_valid && !pending && ($urandom_range(0, 2) != 0);
            req_fire    = ireq_valid && ireq_ready;
            fire_addr   = ireq_addr;

            if (ireq_valid) begin
                checkOutput("rnd req aligned", {30'd0, ireq_addr[1:0]}, 32'd0);
            end
            if (out_valid && out_ready) begin
                deliveries++;
                checkOutput("rnd spurious delivery", 32'(expect_none), 32'd0);
                checkOutput("rnd out_pc", out_pc, exp_pc);
                checkOutput("rnd out_adel", 32'(out_adel), 32'(exp_pc[1:0] != 2'b00));
                checkOutput("rnd out_instr", out_instr,
                            (exp_pc[1:0] != 2'b00) ? 32'd0 : mem_word(exp_pc));
                if (exp_pc[1:0] != 2'b00) begin
                    expect_none = 1'b1;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (redirect_valid) begin
                exp_pc      = redirect_pc;
                expect_none = 1'b0;
            end

            @(posedge clk);
            if (iresp_valid) begin
                pending = 1'b0;
            end else if (pending && resp_delay > 0) begin
                resp_delay--;
            end
            if (req_fire) begin
                pending    = 1'b1;
                resp_delay = $urandom_range(0, 2);
                resp_addr  = fire_addr;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        iresp_valid    = 1'b0;
        checkOutput("rnd forward progress", 32'(deliveries > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
